// File: rtl/mult_pkg.sv
// Shared definitions for the iterative radix-4 Booth multiplier.
//
// Contents:
//   state_e      - controller states (IDLE, BUSY, DONE)
//   booth_sel_e  - Booth digit selection (ZERO, P1, P2, M1, M2)
//   calc_iter    - number of Booth digits for a given operand width
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    P1   = 3'd1,
    P2   = 3'd2,
    M1   = 3'd3,
    M2   = 3'd4
  } booth_sel_e;

  // The multiplier is extended by two bits so that both signed and
  // unsigned operands are valid two's-complement numbers. Each radix-4
  // digit consumes two bits of that extended value.
  function automatic int calc_iter(input int width);
    return width / 2 + 1;
  endfunction

endpackage

// File: rtl/booth_r4_encoder.sv
// Radix-4 Booth digit encoder (combinational).
//
// Ports:
//   window_i  in  3  multiplier bits {b[2i+1], b[2i], b[2i-1]}
//   sel_o     out    selected digit: 0, +A, +2A, -A, -2A
//   neg_o     out 1  digit is negative (the multiplicand is subtracted)
module booth_r4_encoder
  import mult_pkg::*;
(
  input  logic [2:0]  window_i,
  output booth_sel_e  sel_o,
  output logic        neg_o
);

  // Standard radix-4 recoding. Windows 000 and 111 both mean "no
  // contribution"; 111 is excluded from the negate flag so that a zero
  // digit never produces a subtraction.
  always_comb begin
    sel_o = ZERO;
    case (window_i)
      3'b001, 3'b010: sel_o = P1;
      3'b011:         sel_o = P2;
      3'b100:         sel_o = M2;
      3'b101, 3'b110: sel_o = M1;
      default:        sel_o = ZERO;
    endcase
    neg_o = window_i[2] & ~(window_i[1] & window_i[0]);
  end

endmodule

// File: rtl/booth_seq_multiplier.sv
// Iterative radix-4 Booth multiplier, one digit retired per cycle.
//
// Ports:
//   clk          in  1        rising-edge clock
//   rst          in  1        asynchronous active-low reset
//   in_valid     in  1        operands and mode valid
//   in_ready     out 1        block is IDLE and can accept operands
//   a            in  WIDTH    multiplicand
//   b            in  WIDTH    multiplier
//   signed_mode  in  1        1 = two's-complement operands, 0 = unsigned
//   abort        in  1        synchronous cancel while BUSY or DONE
//   busy         out 1        computation in progress
//   out_valid    out 1        product valid (held until out_ready)
//   out_ready    in  1        consumer accepts product
//   product      out 2*WIDTH  a*b in the mode captured at accept
module booth_seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 signed_mode,
  input  logic                 abort,
  output logic                 busy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product
);

  localparam int ITER = calc_iter(WIDTH);
  localparam int EXT  = WIDTH + 2;
  localparam int ACCW = 2 * WIDTH + 4;
  localparam int CW   = $clog2(ITER + 1);

  if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
    $error("booth_seq_multiplier: WIDTH must be even and >= 4");
  end

  state_e              state_q, state_d;
  logic [ACCW-1:0]     acc_q, acc_d;
  logic [ACCW-1:0]     mcand_q, mcand_d;
  logic [EXT:0]        mplr_q, mplr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2*WIDTH-1:0]  product_q, product_d;

  logic [EXT-1:0]      a_ext, b_ext;
  booth_sel_e          sel;
  logic                neg;
  logic [ACCW-1:0]     mag, addend, acc_next;

  // Operands are widened by two bits so one Booth recoding covers both
  // signed and unsigned inputs; the mode only decides the fill bit.
  always_comb begin
    a_ext = {{2{signed_mode & a[WIDTH-1]}}, a};
    b_ext = {{2{signed_mode & b[WIDTH-1]}}, b};
  end

  // The multiplier register carries an extra zero below bit 0 so that
  // its three lowest bits are always the current Booth window.
  booth_r4_encoder u_enc (
    .window_i (mplr_q[2:0]),
    .sel_o    (sel),
    .neg_o    (neg)
  );

  // The multiplicand register is pre-shifted by 4^i each cycle, so the
  // digit is simply 0, A or 2A of that register, optionally negated.
  always_comb begin
    mag = '0;
    case (sel)
      P1, M1:  mag = mcand_q;
      P2, M2:  mag = mcand_q << 1;
      default: mag = '0;
    endcase
    addend   = neg ? (~mag + ACCW'(1)) : mag;
    acc_next = acc_q + addend;
  end

  // Controller and datapath next-state. Abort wins over the final digit
  // so a cancelled operation never updates product; the product
  // register is written only on the last BUSY cycle.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplr_d    = mplr_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          acc_d   = '0;
          mcand_d = {{(ACCW-EXT){a_ext[EXT-1]}}, a_ext};
          mplr_d  = {b_ext, 1'b0};
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          acc_d   = acc_next;
          mcand_d = mcand_q << 2;
          mplr_d  = {{2{mplr_q[EXT]}}, mplr_q[EXT:2]};
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == CW'(ITER - 1)) begin
            product_d = acc_next[2*WIDTH-1:0];
            state_d   = DONE;
          end
        end
      end
      DONE: begin
        if (abort || out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // All state returns to zero immediately on reset, so no partial
  // product can ever be seen on the output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplr_q    <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplr_q    <= mplr_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  // Handshake outputs decode directly from the state register.
  always_comb begin
    in_ready  = (state_q == IDLE);
    busy      = (state_q == BUSY);
    out_valid = (state_q == DONE);
    product   = product_q;
  end

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Self-checking bench for booth_seq_multiplier: a WIDTH=32 instance for
// the directed scenarios and a WIDTH=8 instance for randomized checks
// against a plain-arithmetic reference model.
module tb_booth_seq_multiplier;

  logic clk;
  logic rst;

  logic        inValid32, inReady32, mode32, abort32, busy32, outValid32, outReady32;
  logic [31:0] a32, b32;
  logic [63:0] product32;

  logic        inValid8, inReady8, mode8, abort8, busy8, outValid8, outReady8;
  logic [7:0]  a8, b8;
  logic [15:0] product8;

  int errorCount;
  int checkCount;

  booth_seq_multiplier #(.WIDTH(32)) dut32 (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (inValid32),
    .in_ready    (inReady32),
    .a           (a32),
    .b           (b32),
    .signed_mode (mode32),
    .abort       (abort32),
    .busy        (busy32),
    .out_valid   (outValid32),
    .out_ready   (outReady32),
    .product     (product32)
  );

  booth_seq_multiplier #(.WIDTH(8)) dut8 (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (inValid8),
    .in_ready    (inReady8),
    .a           (a8),
    .b           (b8),
    .signed_mode (mode8),
    .abort       (abort8),
    .busy        (busy8),
    .out_valid   (outValid8),
    .out_ready   (outReady8),
    .product     (product8)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: the exact mathematical product, truncated to 2*W.
  function automatic logic [63:0] model32(input logic [31:0] av, input logic [31:0] bv,
                                          input logic mv);
    logic [63:0] ea, eb;
    ea = mv ? {{32{av[31]}}, av} : {32'b0, av};
    eb = mv ? {{32{bv[31]}}, bv} : {32'b0, bv};
    return ea * eb;
  endfunction

  function automatic logic [15:0] model8(input logic [7:0] av, input logic [7:0] bv,
                                         input logic mv);
    int ia, ib, p;
    ia = int'(av);
    ib = int'(bv);
    if (mv && av[7]) ia = ia - 256;
    if (mv && bv[7]) ib = ib - 256;
    p = ia * ib;
    return p[15:0];
  endfunction

  // Present one operand pair while the DUT is idle; returns just after
  // the accepting edge.
  task automatic start32(input logic [31:0] av, input logic [31:0] bv, input logic mv);
    a32 = av;
    b32 = bv;
    mode32 = mv;
    inValid32 = 1'b1;
    @(posedge clk); #1;
    inValid32 = 1'b0;
    a32 = $urandom;
    b32 = $urandom;
    mode32 = ~mv;
  endtask

  task automatic wait32(output int lat);
    lat = 0;
    while (!outValid32 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume32;
    outReady32 = 1'b1;
    @(posedge clk); #1;
    outReady32 = 1'b0;
  endtask

  task automatic start8(input logic [7:0] av, input logic [7:0] bv, input logic mv);
    a8 = av;
    b8 = bv;
    mode8 = mv;
    inValid8 = 1'b1;
    @(posedge clk); #1;
    inValid8 = 1'b0;
    a8 = 8'($urandom);
    b8 = 8'($urandom);
  endtask

  task automatic wait8(output int lat);
    lat = 0;
    while (!outValid8 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume8;
    outReady8 = 1'b1;
    @(posedge clk); #1;
    outReady8 = 1'b0;
  endtask

  // Outputs while reset is held low.
  task automatic test_reset;
    logic [3:0] got;
    got = {inReady32, busy32, outValid32, inReady8};
    checkCount++;
    if (got !== 4'b1001) begin
      errorCount++;
      $display("[TB] FAIL reset_flags: got %b expected 1001", got);
    end
    checkCount++;
    if (product32 !== 64'd0) begin
      errorCount++;
      $display("[TB] FAIL reset_product32: got %h expected 0", product32);
    end
    checkCount++;
    if ({busy8, outValid8, product8} !== 18'd0) begin
      errorCount++;
      $display("[TB] FAIL reset_dut8: got %b/%b/%h expected 0/0/0", busy8, outValid8, product8);
    end
  endtask

  task automatic test_signed_basic;
    int lat;
    start32(32'hFFFF_FFF9, 32'd6, 1'b1);
    checkCount++;
    if (busy32 !== 1'b1 || inReady32 !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL busy_after_accept: got busy=%b in_ready=%b expected 1/0", busy32, inReady32);
    end
    wait32(lat);
    checkCount++;
    if (lat != 17) begin
      errorCount++;
      $display("[TB] FAIL latency32: got %0d expected 17", lat);
    end
    checkCount++;
    if (product32 !== 64'hFFFF_FFFF_FFFF_FFD6) begin
      errorCount++;
      $display("[TB] FAIL signed_m7x6: got %h expected ffffffffffffffd6", product32);
    end
    consume32;
  endtask

  task automatic test_unsigned_boundary;
    int lat;
    start32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait32(lat);
    checkCount++;
    if (product32 !== 64'hFFFF_FFFE_0000_0001) begin
      errorCount++;
      $display("[TB] FAIL unsigned_ones: got %h expected fffffffe00000001", product32);
    end
    consume32;
    start32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait32(lat);
    checkCount++;
    if (product32 !== 64'd1) begin
      errorCount++;
      $display("[TB] FAIL signed_m1xm1: got %h expected 1", product32);
    end
    consume32;
    start32(32'h8000_0000, 32'h8000_0000, 1'b1);
    wait32(lat);
    checkCount++;
    if (product32 !== 64'h4000_0000_0000_0000) begin
      errorCount++;
      $display("[TB] FAIL signed_minxmin: got %h expected 4000000000000000", product32);
    end
    consume32;
    start32(32'h1234_5678, 32'd0, 1'b1);
    wait32(lat);
    checkCount++;
    if (product32 !== 64'd0) begin
      errorCount++;
      $display("[TB] FAIL times_zero: got %h expected 0", product32);
    end
    consume32;
  endtask

  task automatic test_random32;
    int lat;
    logic [31:0] av, bv;
    logic mv;
    logic [63:0] exp;
    for (int i = 0; i < 20; i++) begin
      av = $urandom;
      bv = $urandom;
      mv = 1'($urandom);
      exp = model32(av, bv, mv);
      start32(av, bv, mv);
      wait32(lat);
      checkCount++;
      if (product32 !== exp || lat != 17) begin
        errorCount++;
        $display("[TB] FAIL random32 %h*%h m=%b: got %h lat %0d expected %h lat 17",
                 av, bv, mv, product32, lat, exp);
      end
      consume32;
    end
  endtask

  task automatic test_backpressure;
    int lat;
    int badCycles;
    start32(32'd5, 32'd9, 1'b0);
    wait32(lat);
    badCycles = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (product32 !== 64'd45 || outValid32 !== 1'b1 || inReady32 !== 1'b0) badCycles++;
    end
    checkCount++;
    if (badCycles != 0) begin
      errorCount++;
      $display("[TB] FAIL hold_stable: got %0d unstable cycles expected 0", badCycles);
    end
    outReady32 = 1'b1;
    inValid32 = 1'b1;
    a32 = 32'd7;
    b32 = 32'd11;
    mode32 = 1'b0;
    @(posedge clk); #1;
    outReady32 = 1'b0;
    checkCount++;
    if (inReady32 !== 1'b1 || busy32 !== 1'b0 || outValid32 !== 1'b0 || product32 !== 64'd45) begin
      errorCount++;
      $display("[TB] FAIL release_to_idle: got rdy=%b busy=%b ov=%b p=%h expected 1/0/0/2d",
               inReady32, busy32, outValid32, product32);
    end
    @(posedge clk); #1;
    inValid32 = 1'b0;
    checkCount++;
    if (busy32 !== 1'b1) begin
      errorCount++;
      $display("[TB] FAIL accept_after_done: got busy=%b expected 1", busy32);
    end
    wait32(lat);
    checkCount++;
    if (product32 !== 64'd77 || lat != 17) begin
      errorCount++;
      $display("[TB] FAIL post_bp_product: got %h lat %0d expected 4d lat 17", product32, lat);
    end
    consume32;
  endtask

  task automatic test_abort;
    int lat;
    int seenValid;
    start32(32'd12, 32'd13, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
    end
    abort32 = 1'b1;
    @(posedge clk); #1;
    abort32 = 1'b0;
    checkCount++;
    if (busy32 !== 1'b0 || inReady32 !== 1'b1 || product32 !== 64'd77) begin
      errorCount++;
      $display("[TB] FAIL abort_busy: got busy=%b rdy=%b p=%h expected 0/1/4d",
               busy32, inReady32, product32);
    end
    seenValid = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (outValid32 === 1'b1) seenValid++;
    end
    checkCount++;
    if (seenValid != 0 || product32 !== 64'd77) begin
      errorCount++;
      $display("[TB] FAIL abort_no_valid: got %0d valid cycles p=%h expected 0 p=4d",
               seenValid, product32);
    end
    start32(32'd3, 32'd5, 1'b0);
    wait32(lat);
    checkCount++;
    if (product32 !== 64'd15 || lat != 17) begin
      errorCount++;
      $display("[TB] FAIL after_abort_3x5: got %h lat %0d expected f lat 17", product32, lat);
    end
    abort32 = 1'b1;
    outReady32 = 1'b1;
    @(posedge clk); #1;
    abort32 = 1'b0;
    outReady32 = 1'b0;
    checkCount++;
    if (outValid32 !== 1'b0 || inReady32 !== 1'b1 || product32 !== 64'd15) begin
      errorCount++;
      $display("[TB] FAIL abort_done: got ov=%b rdy=%b p=%h expected 0/1/f",
               outValid32, inReady32, product32);
    end
    abort32 = 1'b1;
    start32(32'd4, 32'd5, 1'b0);
    abort32 = 1'b0;
    checkCount++;
    if (busy32 !== 1'b1) begin
      errorCount++;
      $display("[TB] FAIL accept_over_abort: got busy=%b expected 1", busy32);
    end
    wait32(lat);
    checkCount++;
    if (product32 !== 64'd20) begin
      errorCount++;
      $display("[TB] FAIL idle_abort_ignored: got %h expected 14", product32);
    end
    consume32;
  endtask

  task automatic test_async_reset;
    start32(32'd100, 32'd200, 1'b0);
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
    end
    #2;
    rst = 1'b0;
    #1;
    checkCount++;
    if (busy32 !== 1'b0 || inReady32 !== 1'b1 || outValid32 !== 1'b0 || product32 !== 64'd0) begin
      errorCount++;
      $display("[TB] FAIL async_reset: got busy=%b rdy=%b ov=%b p=%h expected 0/1/0/0",
               busy32, inReady32, outValid32, product32);
    end
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checkCount++;
    if (inReady32 !== 1'b1 || busy32 !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL after_reset_idle: got rdy=%b busy=%b expected 1/0", inReady32, busy32);
    end
  endtask

  task automatic test_random8;
    int lat;
    int badCount;
    logic [7:0] av, bv;
    logic mv;
    logic [15:0] exp;
    start8(8'h80, 8'h80, 1'b1);
    wait8(lat);
    checkCount++;
    if (product8 !== 16'd16384 || lat != 5) begin
      errorCount++;
      $display("[TB] FAIL w8_minxmin: got %0d lat %0d expected 16384 lat 5", product8, lat);
    end
    consume8;
    start8(8'hFF, 8'hFF, 1'b0);
    wait8(lat);
    checkCount++;
    if (product8 !== 16'd65025 || lat != 5) begin
      errorCount++;
      $display("[TB] FAIL w8_255x255: got %0d lat %0d expected 65025 lat 5", product8, lat);
    end
    consume8;
    badCount = 0;
    for (int i = 0; i < 500; i++) begin
      av = 8'($urandom);
      bv = 8'($urandom);
      mv = 1'($urandom);
      exp = model8(av, bv, mv);
      start8(av, bv, mv);
      wait8(lat);
      checkCount++;
      if (product8 !== exp || lat != 5) begin
        errorCount++;
        badCount++;
        if (badCount <= 10)
          $display("[TB] FAIL w8_random %h*%h m=%b: got %h lat %0d expected %h lat 5",
                   av, bv, mv, product8, lat, exp);
      end
      consume8;
    end
  endtask

  initial begin
    errorCount = 0;
    checkCount = 0;
    rst = 1'b0;
    inValid32 = 1'b0; a32 = '0; b32 = '0; mode32 = 1'b0; abort32 = 1'b0; outReady32 = 1'b0;
    inValid8 = 1'b0; a8 = '0; b8 = '0; mode8 = 1'b0; abort8 = 1'b0; outReady8 = 1'b0;
    #12;
    test_reset;
    rst = 1'b1;
    @(posedge clk); #1;
    test_signed_basic;
    test_unsigned_boundary;
    test_random32;
    test_backpressure;
    test_abort;
    test_async_reset;
    test_random8;
    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/booth_seq_multiplier.md
Name: booth_seq_multiplier

Overview:
- Parametrised, iterative radix-4 Booth multiplier; the next generation after the fixed 32-bit registered multiplier.
- Accepts one operand pair per transaction over a valid/ready handshake.
- Retires one Booth digit per cycle and holds the 2*WIDTH product until the consumer accepts it.
- Adds a runtime signed/unsigned mode and a synchronous abort; sits between the operand buffers and the result buffer of the datapath.

Parameters:
- WIDTH, 32, operand width in bits; must be even and >= 4 (elaboration error otherwise).
- ITER, WIDTH/2+1, derived Booth digit count over the WIDTH+2-bit extended multiplier; not overridable.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands and mode valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- signed_mode  input  1  1 = two's-complement operands, 0 = unsigned.
- abort  input  1  synchronous cancel of the current operation.
- busy  output  1  high while in BUSY.
- out_valid  output  1  product valid.
- out_ready  input  1  consumer accepts product.
- product  output  2*WIDTH  a*b, signed or unsigned per captured mode.

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE; out_valid = 0, busy = 0, product = 0.
  - Internal accumulator, operand and iteration counter registers = 0.
  - in_ready = 1 while held in reset and after release.
- States: IDLE, BUSY, DONE.
  - in_ready = (state == IDLE); busy = (state == BUSY); out_valid = (state == DONE).
- IDLE:
  - On in_valid && in_ready at edge E0: capture a, b and signed_mode.
  - Extend both operands to WIDTH+2 bits: sign-extend if signed_mode = 1, zero-extend otherwise.
  - Clear accumulator; counter = 0; go to BUSY.
- BUSY, one cycle per digit:
  - Booth window = {b_ext[2i+1], b_ext[2i], b_ext[2i-1]}, with b_ext[-1] = 0.
  - Digit select: 0, +A, +2A, -A, -2A; the digit is added into the accumulator at weight 4^i.
  - Arithmetic is performed at 2*WIDTH+4 bits; product is the low 2*WIDTH bits.
  - After ITER cycles (counter == ITER-1 at the edge): latch product, go to DONE.
  - out_valid rises after edge E0+ITER, i.e. 17 cycles for WIDTH = 32. Latency is fixed and data-independent.
- DONE:
  - product and out_valid are held stable while out_ready = 0.
  - On out_ready: go to IDLE. product keeps its last value; out_valid falls.
  - No back-to-back accept in the DONE cycle; the next accept is earliest one cycle later.
- abort:
  - In BUSY or DONE: at the next edge go to IDLE; out_valid = 0; the partial result is discarded and product is not updated.
  - Ignored in IDLE. In the same IDLE cycle as in_valid, the accept takes priority.
  - abort && out_ready in DONE: treated as abort; product is not consumed.
- Input changes outside the accept edge have no effect on the computation.
- Boundary results:
  - Signed: most-negative * most-negative = +2^(2*WIDTH-2), exact.
  - Unsigned: all-ones * all-ones = (2^WIDTH-1)^2, exact.
  - Either operand 0 gives 0. There is no overflow; the full product always fits in 2*WIDTH bits.
- Reset asserted mid-operation: immediate return to reset values; no partial product ever appears on product.

Decomposition:
- Package mult_pkg:
  - state enum {IDLE, BUSY, DONE}.
  - Booth select enum {ZERO, P1, P2, M1, M2}.
  - Function computing ITER from WIDTH.
- Sub-module booth_r4_encoder (combinational): 3-bit window in, select enum out, plus negate flag. Instantiated once; the top handles the accumulator, counter, FSM and handshakes.

Test Plan:
- Signed WIDTH=32: a = -7, b = 6, signed_mode = 1 -> product = 64'hFFFF_FFFF_FFFF_FFD6 (-42); out_valid exactly 17 cycles after accept.
- Unsigned WIDTH=32: a = b = 32'hFFFF_FFFF, signed_mode = 0 -> product = 64'hFFFF_FFFE_0000_0001. Same bits with signed_mode = 1 -> product = 1.
- Backpressure: hold out_ready = 0 for 10 cycles after out_valid -> product and out_valid stable, in_ready = 0. Raise out_ready -> IDLE next cycle; the new accept succeeds one cycle later.
- Abort at BUSY cycle 5 -> IDLE next edge, out_valid never asserts, product keeps its previous value. A following 3*5 returns 15.
- Async reset: drop rst at BUSY cycle 8 without a clock edge -> busy = 0, product = 0, in_ready = 1 immediately.
- WIDTH=8 instance with 500 random signed and unsigned pairs, including -128*-128 = 16384 and 255*255 = 65025 -> matches the reference model; latency = 5 cycles.
